// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD saturating add/subtract unit.
//   - Mode encodings for the per-beat arithmetic mode.
//   - Saturation limit helpers. Each helper takes a lane width and returns
//     the limit zero-extended to 64 bits. Callers slice the low bits of the
//     result after storing it in a localparam.
package simd_pkg;

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SSAT = 2'b01;
  localparam logic [1:0] MODE_USAT = 2'b10;

  // Largest signed value: 0111..1
  function automatic logic [63:0] ssat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative signed value: 1000..0
  function automatic logic [63:0] ssat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Largest unsigned value: 1111..1
  function automatic logic [63:0] usat_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/simd_sat_lane.sv
// One combinational SIMD lane: a +/- b with wrap, signed-saturating or
// unsigned-saturating result.
// Ports:
//   a, b  : lane operands (LANE_W bits)
//   sub   : 1 = a-b, 0 = a+b
//   mode  : MODE_WRAP / MODE_SSAT / MODE_USAT (2'b11 behaves as MODE_SSAT)
//   r     : lane result
//   sat   : 1 when the result was clamped
module simd_sat_lane
  import simd_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  input  logic [1:0]        mode,
  output logic [LANE_W-1:0] r,
  output logic              sat
);

  localparam logic [63:0] SMAX64 = ssat_max(LANE_W);
  localparam logic [63:0] SMIN64 = ssat_min(LANE_W);
  localparam logic [63:0] UMAX64 = usat_max(LANE_W);
  localparam logic [LANE_W-1:0] SMAX = SMAX64[LANE_W-1:0];
  localparam logic [LANE_W-1:0] SMIN = SMIN64[LANE_W-1:0];
  localparam logic [LANE_W-1:0] UMAX = UMAX64[LANE_W-1:0];

  // One extra bit holds every exact sum/difference, including 0 - (most negative).
  logic signed [LANE_W:0] sa;
  logic signed [LANE_W:0] sb;
  logic signed [LANE_W:0] s_exact;
  logic        [LANE_W:0] u_exact;

  always_comb begin
    sa      = signed'({a[LANE_W-1], a});
    sb      = signed'({b[LANE_W-1], b});
    s_exact = sub ? (sa - sb) : (sa + sb);
    // Top bit doubles as carry on add and borrow on subtract.
    u_exact = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r       = u_exact[LANE_W-1:0];
    sat     = 1'b0;
    case (mode)
      MODE_WRAP: ;
      MODE_USAT: begin
        if (u_exact[LANE_W]) begin
          sat = 1'b1;
          r   = sub ? '0 : UMAX;
        end
      end
      default: begin
        // Sign bit and the bit below it disagree only on overflow; the
        // sign of the exact value picks the clamp direction.
        r = s_exact[LANE_W-1:0];
        if (!s_exact[LANE_W] && s_exact[LANE_W-1]) begin
          sat = 1'b1;
          r   = SMAX;
        end else if (s_exact[LANE_W] && !s_exact[LANE_W-1]) begin
          sat = 1'b1;
          r   = SMIN;
        end
      end
    endcase
  end

endmodule

// File: rtl/simd_sat_addsub_pipe.sv
// Two-stage pipelined SIMD add/subtract with per-lane wrap or saturation,
// a valid/ready handshake on both sides and sticky saturation flags.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : operand beat handshake
//   a, b                : packed operands, lane i = x[i*LANE_W +: LANE_W]
//   sub, mode           : per-beat operation and arithmetic mode
//   out_valid/out_ready : result beat handshake
//   result, sat         : packed lane results and per-lane saturation
//   sat_sticky          : OR of sat over consumed beats since reset/clear
//   clr_sticky          : clear sat_sticky (keeps sat of a same-cycle transfer)
module simd_sat_addsub_pipe
  import simd_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANE_W*LANES-1:0]  a,
  input  logic [LANE_W*LANES-1:0]  b,
  input  logic                     sub,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANE_W*LANES-1:0]  result,
  output logic [LANES-1:0]         sat,
  output logic [LANES-1:0]         sat_sticky,
  input  logic                     clr_sticky
);

  localparam int DATA_W = LANE_W * LANES;

  logic              vld_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              sub_p1;
  logic [1:0]        mode_p1;

  logic              vld_p2;
  logic [DATA_W-1:0] result_p2;
  logic [LANES-1:0]  sat_p2;
  logic [LANES-1:0]  sticky_p2;

  logic [DATA_W-1:0] lane_r;
  logic [LANES-1:0]  lane_sat;

  logic load_p2;
  logic adv_p1;
  logic in_xfer;
  logic out_xfer;

  assign load_p2  = !vld_p2 || out_ready;
  assign adv_p1   = load_p2;
  assign in_ready = !vld_p1 || adv_p1;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = vld_p2 && out_ready;

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      a_p1    <= a;
      b_p1    <= b;
      sub_p1  <= sub;
      mode_p1 <= mode;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_sat_lane #(.LANE_W(LANE_W)) u_lane (
      .a    (a_p1[i*LANE_W +: LANE_W]),
      .b    (b_p1[i*LANE_W +: LANE_W]),
      .sub  (sub_p1),
      .mode (mode_p1),
      .r    (lane_r[i*LANE_W +: LANE_W]),
      .sat  (lane_sat[i])
    );
  end

  // Stage 2: result register and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      sat_p2    <= '0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        result_p2 <= lane_r;
        sat_p2    <= lane_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_p2 <= '0;
    end else if (clr_sticky) begin
      sticky_p2 <= out_xfer ? sat_p2 : '0;
    end else if (out_xfer) begin
      sticky_p2 <= sticky_p2 | sat_p2;
    end
  end

  assign out_valid  = vld_p2;
  assign result     = result_p2;
  assign sat        = sat_p2;
  assign sat_sticky = sticky_p2;

endmodule

// File: tb/tb_simd_sat_addsub_pipe.sv
module tb_simd_sat_addsub_pipe;

  localparam int LANE_W = 4;
  localparam int LANES  = 4;
  localparam int DATA_W = LANE_W * LANES;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] a = '0;
  logic [DATA_W-1:0] b = '0;
  logic              sub = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] result;
  logic [LANES-1:0]  sat;
  logic [LANES-1:0]  sat_sticky;
  logic              clr_sticky = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  simd_sat_addsub_pipe #(.LANE_W(LANE_W), .LANES(LANES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .sat        (sat),
    .sat_sticky (sat_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {sat, result} from integer arithmetic on each lane.
  function automatic logic [LANES+DATA_W-1:0] model(input logic [DATA_W-1:0] ma,
      input logic [DATA_W-1:0] mb, input logic msub, input logic [1:0] mmode);
    logic [DATA_W-1:0] res;
    logic [LANES-1:0]  s;
    int hi, lo, span;
    span = 1 << LANE_W;
    hi   = (1 << (LANE_W - 1)) - 1;
    lo   = -(1 << (LANE_W - 1));
    res  = '0;
    s    = '0;
    for (int i = 0; i < LANES; i++) begin
      int ua, ub, sa, sb, v;
      ua = int'(ma[i*LANE_W +: LANE_W]);
      ub = int'(mb[i*LANE_W +: LANE_W]);
      sa = (ua > hi) ? ua - span : ua;
      sb = (ub > hi) ? ub - span : ub;
      if (mmode == 2'b10) begin
        v = msub ? ua - ub : ua + ub;
        if (v > span - 1) begin v = span - 1; s[i] = 1'b1; end
        else if (v < 0)   begin v = 0;        s[i] = 1'b1; end
      end else if (mmode == 2'b00) begin
        v = msub ? ua - ub : ua + ub;
      end else begin
        v = msub ? sa - sb : sa + sb;
        if (v > hi)      begin v = hi; s[i] = 1'b1; end
        else if (v < lo) begin v = lo; s[i] = 1'b1; end
      end
      v = ((v % span) + span) % span;
      res[i*LANE_W +: LANE_W] = LANE_W'(v);
    end
    return {s, res};
  endfunction

  // Scoreboard: sampled 1 ns before each rising edge.
  logic [LANES+DATA_W-1:0] exp_q[$];
  logic [LANES-1:0]        sticky_m = '0;
  logic                    stalled_prev = 1'b0;
  logic [DATA_W-1:0]       held_res;

  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      exp_q.delete();
      sticky_m     = '0;
      stalled_prev = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_sticky", 32'(sat_sticky), 32'd0);
    end else begin
      logic [LANES+DATA_W-1:0] e;
      logic xfer;
      chk("sticky", 32'(sat_sticky), 32'(sticky_m));
      if (stalled_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", 32'(result), 32'(held_res));
      end
      xfer = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q[0];
          chk("result", 32'(result), 32'(e[DATA_W-1:0]));
          chk("sat", 32'(sat), 32'(e[LANES+DATA_W-1:DATA_W]));
          if (out_ready) begin
            xfer = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
      if (clr_sticky) sticky_m = xfer ? sat : '0;
      else if (xfer)  sticky_m = sticky_m | sat;
      stalled_prev = out_valid && !out_ready;
      held_res     = result;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, mode));
      if (exp_q.size() > 2) chk("in_flight_le_2", 32'(exp_q.size()), 32'd2);
    end
  end

  // Entered and left 1 ns after a rising edge; leaves in_valid high.
  task automatic send(input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb,
                      input logic vsub, input logic [1:0] vmode);
    int tries;
    logic acc;
    in_valid = 1'b1; a = va; b = vb; sub = vsub; mode = vmode;
    tries = 0;
    do begin
      @(negedge clk); #1;
      acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end while (!acc && tries < 50);
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while (exp_q.size() != 0 && tries < 50) begin
      @(posedge clk); #1;
      tries++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clr_pulse();
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
  endtask

  initial begin
    // Hand-computed literals pinning the reference model.
    chk("m_sadd", 32'(model(16'h718F, 16'h12F1, 1'b0, 2'b01)), 32'({4'b1010, 16'h7380}));
    chk("m_ssub", 32'(model(16'h0873, 16'h81F3, 1'b1, 2'b01)), 32'({4'b1110, 16'h7870}));
    chk("m_uadd", 32'(model(16'hF801, 16'h1802, 1'b0, 2'b10)), 32'({4'b1100, 16'hFF03}));
    chk("m_usub", 32'(model(16'h1050, 16'h2030, 1'b1, 2'b10)), 32'({4'b1000, 16'h0020}));
    chk("m_wrap", 32'(model(16'hF801, 16'h1802, 1'b0, 2'b00)), 32'({4'b0000, 16'h0003}));
    chk("m_mode3", 32'(model(16'h718F, 16'h12F1, 1'b0, 2'b11)), 32'({4'b1010, 16'h7380}));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_result", 32'(result), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: signed add with 2-cycle latency
    send(16'h718F, 16'h12F1, 1'b0, 2'b01);
    in_valid = 1'b0;
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_result", 32'(result), 32'h7380);
    chk("t1_sat", 32'(sat), 32'b1010);
    drain();

    // Tests 2-3: signed subtract, unsigned, wrap, streamed back-to-back
    send(16'h0873, 16'h81F3, 1'b1, 2'b01);
    send(16'hF801, 16'h1802, 1'b0, 2'b10);
    send(16'h1050, 16'h2030, 1'b1, 2'b10);
    send(16'hF801, 16'h1802, 1'b0, 2'b00);
    send(16'h0080, 16'h0080, 1'b1, 2'b11);
    in_valid = 1'b0;
    drain();

    // Test 4: backpressure
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 2'b00);
    send(16'h7000, 16'h1000, 1'b0, 2'b01);
    in_valid = 1'b1; a = 16'h0001; b = 16'h0002; sub = 1'b1; mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'(result), 32'h3333);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(16'h0001, 16'h0002, 1'b1, 2'b10);
    in_valid = 1'b0;
    drain();

    // Test 5: sticky flags
    clr_pulse();
    chk("s5_cleared", 32'(sat_sticky), 32'd0);
    send(16'h718F, 16'h12F1, 1'b0, 2'b01);
    send(16'h0007, 16'h0001, 1'b0, 2'b01);
    in_valid = 1'b0;
    drain();
    @(negedge clk); #1;
    chk("s5_or", 32'(sat_sticky), 32'b1011);
    @(posedge clk); #1;
    send(16'h0700, 16'h0100, 1'b0, 2'b01);
    in_valid = 1'b0;
    begin
      int tries;
      tries = 0;
      do begin
        @(negedge clk); #1;
        tries++;
      end while (!out_valid && tries < 20);
      chk("s5_wait", 32'(out_valid), 32'd1);
    end
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    chk("s5_clr_xfer", 32'(sat_sticky), 32'b0100);
    clr_pulse();
    chk("s5_clr_idle", 32'(sat_sticky), 32'd0);

    // Test 6: reset with two beats in flight
    send(16'h8000, 16'h8000, 1'b0, 2'b01);
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 2'b00);
    send(16'h4321, 16'h1111, 1'b1, 2'b00);
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("r6_sticky_before", 32'(sat_sticky), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk("r6_out_valid", 32'(out_valid), 32'd0);
    chk("r6_sticky", 32'(sat_sticky), 32'd0);
    chk("r6_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("r6_no_spurious", 32'(out_valid), 32'd0);

    // Pipeline still usable after reset
    send(16'h0F0F, 16'h0101, 1'b0, 2'b10);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_sat_addsub_pipe.md
Name: simd_sat_addsub_pipe

Overview:
Parametrised, pipelined SIMD add/subtract unit for the Execute stage, the next generation of the packed half-byte saturating adder. It splits each DATA_W operand into LANES independent lanes of LANE_W bits. Each lane returns a wrapped, signed-saturated or unsigned-saturated sum or difference. A valid/ready handshake on each side lets it stall with the pipeline, and sticky per-lane saturation flags are kept for status reporting.

Parameters:
LANE_W, 4, bits per lane (>=2)
LANES, 4, number of lanes; DATA_W = LANE_W*LANES (default 16)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept operand beat
a  in  DATA_W  operand A; lane i = a[i*LANE_W +: LANE_W]
b  in  DATA_W  operand B, same lane layout
sub  in  1  1 = A-B, 0 = A+B
mode  in  2  00 wrap, 01 signed sat, 10 unsigned sat, 11 treated as 01
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
result  out  DATA_W  packed lane results
sat  out  LANES  per-lane saturation of the current result beat
sat_sticky  out  LANES  OR of sat over all consumed beats since reset/clear
clr_sticky  in  1  clear sat_sticky

Behaviour:
- Reset (async assert, sync deassert on the clk edge):
  - out_valid=0, result=0, sat=0, sat_sticky=0.
  - Both stage-valid flags=0, so in_ready=1 after reset.
- Pipeline: S1 registers a, b, sub, mode. S2 registers result and sat. Latency is 2 cycles from in_valid&&in_ready to out_valid with no backpressure.
- Handshake:
  - An input transfer occurs on in_valid&&in_ready.
  - An output transfer occurs on out_valid&&out_ready.
  - S2 loads when it is empty or being consumed.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || s1_advance (combinational, no dependency on in_valid).
  - Throughput is 1 beat/cycle.
  - result/sat hold stable while out_valid&&!out_ready.
  - Beats are never dropped, duplicated or reordered.
  - At most 2 beats are in flight.
- Per-lane arithmetic: compute the exact value in LANE_W+1 bits, then apply the mode.
  - Signed: r = sext(a_i) +/- sext(b_i).
    - r > 2^(LANE_W-1)-1 -> 0111..1, sat_i=1.
    - r < -2^(LANE_W-1) -> 1000..0, sat_i=1.
    - Otherwise r[LANE_W-1:0].
    - Saturation direction comes from the sign of the exact result, not from sub.
    - B = most-negative is handled exactly in subtract.
  - Unsigned: r = zext(a_i) +/- zext(b_i).
    - Carry out on add -> all ones, sat_i=1.
    - Borrow on subtract -> 0, sat_i=1.
  - Wrap: r[LANE_W-1:0], sat_i=0.
  - Lanes are fully independent; no carry crosses a lane boundary.
- sat_sticky: on each output transfer, sat_sticky |= sat.
  - clr_sticky alone clears to 0.
  - clr_sticky together with an output transfer gives sat_sticky = sat of that beat.
- Reset mid-operation: all in-flight beats are discarded; no stale out_valid after reset releases.
- Mode and sub are sampled per beat, so mixed modes can stream back-to-back.

Decomposition:
- Package simd_pkg holds the mode constants MODE_WRAP=2'b00, MODE_SSAT=2'b01, MODE_USAT=2'b10 and the saturation-limit helper functions.
- One combinational sub-module, simd_sat_lane (params LANE_W; ports a, b, sub, mode, r, sat), instantiated LANES times by generate.
- Pipeline registers, handshake and sticky logic live in the top module.

Test Plan (defaults LANE_W=4, LANES=4, lane3 = MSB nibble):
1. Signed add: mode=01, sub=0, a=16'h718F, b=16'h12F1 -> result=16'h7380, sat=4'b1010, out_valid 2 cycles after accept.
2. Signed subtract: mode=01, sub=1, a=16'h0873, b=16'h81F3 -> result=16'h7870, sat=4'b1110 (0-(-8) clamps to 7).
3. Unsigned: mode=10, sub=0, a=16'hF801, b=16'h1802 -> 16'hFF03, sat=4'b1100. Then sub=1, a=16'h1050, b=16'h2030 -> 16'h0020, sat=4'b1000. Wrap: mode=00, sub=0, a=16'hF801, b=16'h1802 -> 16'h0003, sat=0.
4. Backpressure: hold out_ready=0, offer 3 back-to-back beats -> in_ready drops after 2 accepted, result stable. Release out_ready -> all 3 emerge in order, 1 per cycle.
5. Sticky: run test 1, then a beat with sat=0001 -> sat_sticky=1011. Assert clr_sticky with a sat=0100 transfer -> sat_sticky=0100. clr_sticky with no transfer -> 0000.
6. Reset mid-flight: assert rst_n=0 while 2 beats are in flight -> immediate out_valid=0, sat_sticky=0, in_ready=1. No spurious output after release.
